// File: rtl/shift_result_fifo_if.sv
// Handshake/result bus between the barrel shifter, the result FIFO and the ALU result bus.
// Optional statistics signals exist only when SHIFT_RESULT_FIFO_STATS_EN is defined.
interface shift_result_fifo_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
);
   logic [WIDTH-1:0] in_data;
   logic [4:0]       in_amt;
   logic             in_ctl0;
   logic             in_ctl1;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;
   logic             out_neg;
   logic             out_nop;
   logic             out_arith;
   logic             out_valid;
   logic             out_ready;
   logic [PTR_W:0]   count;
`ifdef SHIFT_RESULT_FIFO_STATS_EN
   logic [15:0]      stat_pushes;
   logic [15:0]      stat_stalls;
`endif

   // master: the side that presents results and consumes the head (shifter + result bus)
   modport master (
      output in_data, in_amt, in_ctl0, in_ctl1, in_valid, out_ready,
      input  in_ready, out_data, out_zero, out_neg, out_nop, out_arith, out_valid, count
`ifdef SHIFT_RESULT_FIFO_STATS_EN
      , input stat_pushes, stat_stalls
`endif
   );

   modport slave (
      input  in_data, in_amt, in_ctl0, in_ctl1, in_valid, out_ready,
      output in_ready, out_data, out_zero, out_neg, out_nop, out_arith, out_valid, count
`ifdef SHIFT_RESULT_FIFO_STATS_EN
      , output stat_pushes, stat_stalls
`endif
   );
endinterface

// File: rtl/shift_result_fifo.sv
// Flow-controlled output stage for the 32-bit barrel shifter: captures result + flags into a FIFO.
// Optional push/stall statistics counters are enabled by defining SHIFT_RESULT_FIFO_STATS_EN.
module shift_result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic              clk,
   input  logic              rst,
   shift_result_fifo_if.slave bus
);

   typedef struct packed {
      logic zero;
      logic neg;
      logic nop;
      logic arith;
   } flags_t;

   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [WIDTH-1:0] r_mem_data  [DEPTH];
   flags_t           r_mem_flags [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic   w_in_ready;
   logic   w_out_valid;
   logic   w_push;
   logic   w_pop;
   flags_t w_in_flags;
   flags_t w_head_flags;

   // Ready depends on occupancy only, so out_ready never reaches in_ready combinationally.
   assign w_in_ready  = (r_count != CNT_FULL);
   assign w_out_valid = (r_count != '0);
   assign w_push      = bus.in_valid && w_in_ready;
   assign w_pop       = w_out_valid && bus.out_ready;

   always_comb begin
      w_in_flags.zero  = (bus.in_data == '0);
      w_in_flags.neg   = bus.in_data[WIDTH-1];
      w_in_flags.nop   = (bus.in_amt == 5'd0);
      w_in_flags.arith = !bus.in_ctl0 && bus.in_ctl1;
   end

   // NOTE: storage carries no reset; stale entries are hidden by the out_valid mask below.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem_data[r_wr_ptr]  <= bus.in_data;
         r_mem_flags[r_wr_ptr] <= w_in_flags;
      end
   end

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head_flags = w_out_valid ? r_mem_flags[r_rd_ptr] : '0;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_valid ? r_mem_data[r_rd_ptr] : '0;
   assign bus.out_zero  = w_head_flags.zero;
   assign bus.out_neg   = w_head_flags.neg;
   assign bus.out_nop   = w_head_flags.nop;
   assign bus.out_arith = w_head_flags.arith;
   assign bus.count     = r_count;

`ifdef SHIFT_RESULT_FIFO_STATS_EN
   logic [15:0] r_stat_pushes;
   logic [15:0] r_stat_stalls;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_pushes <= '0;
         r_stat_stalls <= '0;
      end else begin
         if (w_push && r_stat_pushes != 16'hFFFF)
            r_stat_pushes <= r_stat_pushes + 16'd1;
         if (bus.in_valid && !w_in_ready && r_stat_stalls != 16'hFFFF)
            r_stat_stalls <= r_stat_stalls + 16'd1;
      end
   end

   assign bus.stat_pushes = r_stat_pushes;
   assign bus.stat_stalls = r_stat_stalls;
`endif

endmodule

// File: doc/shift_result_fifo.md
Name: shift_result_fifo

Overview:
- Registered output stage directly downstream of the 32-bit barrel shifter.
- Captures each shifter result together with its shift amount and mode controls.
- Derives status flags and buffers results in a small FIFO with a valid/ready handshake, so the ALU result bus can stall without stalling the shifter's operand source.
- Turns the purely combinational shift path into a flow-controlled pipeline stage.

Parameters:
- WIDTH, 32, data width of shifter result; fixed at 32 for this ALU, kept as a parameter for the bench.
- DEPTH, 2, number of FIFO entries; power of two, legal range 2..16.
- PTR_W, 1, pointer width, equals log2(DEPTH); the instantiating level sets it consistently with DEPTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_data  input  WIDTH  shifter result (shifter "out")
- in_amt  input  5  shift amount (shifter B[4:0])
- in_ctl0  input  1  1 = logical, 0 = arithmetic (as applied to the shifter)
- in_ctl1  input  1  1 = right, 0 = left (as applied to the shifter)
- in_valid  input  1  upstream presents a result this cycle
- in_ready  output  1  stage can accept a push this cycle
- out_data  output  WIDTH  head-entry result
- out_zero  output  1  head result == 0
- out_neg  output  1  head result bit [WIDTH-1]
- out_nop  output  1  head entry had in_amt == 0 (pass-through shift)
- out_arith  output  1  head entry was an arithmetic right shift (ctl0=0, ctl1=1)
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head this cycle
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset: synchronous, active-high, sampled on clk rising edge. Clears write ptr, read ptr and count to 0, and sets out_valid=0. All outputs read 0 and in_ready=1 in the first cycle after reset. Storage contents are not cleared but are masked.
- Reset mid-operation discards all buffered entries. A push or pop presented in the reset cycle has no effect.
- Push: occurs when in_valid && in_ready. Writes entry {in_data, flags} at the write pointer, and the write pointer increments modulo DEPTH.
- Flags are computed at push time from inputs: zero = (in_data==0), neg = in_data[WIDTH-1], nop = (in_amt==0), arith = (!in_ctl0 && in_ctl1).
- Pop: occurs when out_valid && out_ready. The read pointer increments modulo DEPTH.
- in_ready = (count != DEPTH). It is a registered-state function only, with no combinational path from out_ready.
- out_valid = (count != 0).
- out_data and all out_* flags show the head entry when out_valid=1, and are forced to 0 when out_valid=0.
- Latency: a push into an empty FIFO appears at out_valid in the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop, 0 < count < DEPTH: both occur, count is unchanged, and the pointers both advance.
- Push when empty: out_valid rises next cycle even if out_ready was already high.
- Full (count==DEPTH): in_ready=0, and a push is refused even if a pop happens the same cycle. in_ready rises the cycle after the pop.
- Pop when empty: ignored, since out_valid=0.
- Pointer wrap-around: at DEPTH-1 the next value is 0, and ordering is strictly FIFO across the wrap.
- Holding rule: head data and flags are stable while out_valid=1 && out_ready=0.
- count updates: +1 on push only, −1 on pop only, unchanged on both or neither.

Optional Feature:
- Macro: SHIFT_RESULT_FIFO_STATS_EN.
- When defined:
  - Adds output port stat_pushes [15:0], a saturating count of accepted pushes since reset.
  - Adds output port stat_stalls [15:0], a saturating count of cycles with in_valid=1 && in_ready=0.
  - Both counters reset to 0 on rst and hold at 16'hFFFF.
- When undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Reset with in_valid=1 held: for the whole reset cycle no push occurs. Next cycle count=0, out_valid=0, out_data=0, in_ready=1.
- Single push in_data=32'h8000_0000, in_amt=5'd31, ctl0=0, ctl1=1, out_ready=0:
  - One cycle later out_valid=1, out_data=32'h8000_0000, out_neg=1, out_zero=0, out_nop=0, out_arith=1, count=1.
  - Raising out_ready pops it, and out_valid=0 next cycle.
- Fill with out_ready=0 by pushing 32'h1, 32'h2 (DEPTH=2):
  - count=2 and in_ready=0. A third push of 32'h3 is refused.
  - Then out_ready=1 for one cycle with in_valid=1: 32'h1 pops, 32'h3 is not accepted that cycle, and is accepted the next cycle.
  - Drain order is 32'h2, 32'h3.
- Streaming: in_valid=out_ready=1 for 10 cycles with data 0..9, in_amt=0:
  - Outputs 0..9 in order, one per cycle after the 1-cycle latency, count stays 1.
  - First entry has out_zero=1; all entries have out_nop=1.
- Wrap and hold: push 5 values with intermittent out_ready (pattern 1,0,0,1,1,...):
  - Exercises pointer wrap ≥2 times; all values emerge in order.
  - out_data stays stable while stalled.
- Stats (macro defined): hold in_valid=1 with out_ready=0 for 6 cycles from empty.
  - stat_pushes=2, stat_stalls=4.
  - Preloading stat_pushes near saturation (via long stream) shows it holds at 16'hFFFF.
